uart_tx: RTL and testbench

Serial transmitter for the UART, directly downstream of the CPU interface block. Takes the byte written by the CPU together with the mode fields decoded by the CPU interface (parity, data length, stop bits, break, baud divisor), and serialises the byte on TXD. Double-buffered with a holding register and a shift register. Returns `tx_rdy`/`tx_empty` status to the CPU interface.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_gen.sv | 33 +++
 rtl/uart_tx.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity field layout and divisor width.
package uart_pkg;

  localparam int unsigned DIV_W    = 32;
  localparam int unsigned PAR_EN   = 0;
  localparam int unsigned PAR_EVEN = 1;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop1  = 3'd4,
    StStop2  = 3'd5
  } uart_state_e;

  // A divisor of zero behaves as one cycle per bit.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] div);
    return (div == '0) ? DIV_W'(1) : div;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..div-1 and emits a one-cycle tick on the terminal count.
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_m1;

  assign div_m1 = eff_div(div) - DIV_W'(1);
  assign tick   = !restart && (cnt_q == div_m1);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with holding register and shifter. Break masking of TXD is built only when
// UART_TX_BREAK_EN is defined; otherwise break_en is ignored.
module uart_tx
  import uart_pkg::*;
(
  input  logic             CLK50M,
  input  logic             RST,
  input  logic [7:0]       tx_data_in,
  input  logic             tx_load,
  input  logic [1:0]       parity,
  input  logic             eight_data_bits,
  input  logic             extra_stop_bit,
  input  logic             break_en,
  input  logic [DIV_W-1:0] clk_div_baud_in,
  output logic             TXD,
  output logic             tx_rdy,
  output logic             tx_empty,
  output logic             tx_overrun
);

  uart_state_e      state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             par_bit_q, par_bit_d;
  logic             par_en_q, par_en_d;
  logic             eight_q, eight_d;
  logic             two_stop_q, two_stop_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             txd_q, txd_d;
  logic             busy_q;
  logic             overrun_q;

  logic             tick;
  logic             restart;
  logic             transfer;
  logic             frame_bit;
  logic [7:0]       hold_masked;

  assign restart     = (state_q == StIdle);
  assign hold_masked = {eight_data_bits & hold_q[7], hold_q[6:0]};

  uart_baud_gen u_baud_gen (
    .clk     (CLK50M),
    .rst     (RST),
    .restart (restart),
    .div     (div_q),
    .tick    (tick)
  );

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    par_bit_d    = par_bit_q;
    par_en_d     = par_en_q;
    eight_d      = eight_q;
    two_stop_d   = two_stop_q;
    div_d        = div_q;
    transfer     = 1'b0;

    // A load while the holding register is full is dropped (and flagged as overrun).
    if (tx_load && !hold_valid_q) begin
      hold_d       = tx_data_in;
      hold_valid_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (hold_valid_q) begin
          transfer = 1'b1;
        end
      end
      StStart: begin
        if (tick) begin
          state_d   = StData;
          bit_cnt_d = 3'd0;
        end
      end
      StData: begin
        if (tick) begin
          if (bit_cnt_q == (eight_q ? 3'd7 : 3'd6)) begin
            state_d = par_en_q ? StParity : StStop1;
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (tick) begin
          state_d = StStop1;
        end
      end
      StStop1: begin
        if (tick) begin
          if (two_stop_q) begin
            state_d = StStop2;
          end else if (hold_valid_q) begin
            transfer = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StStop2: begin
        if (tick) begin
          if (hold_valid_q) begin
            transfer = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Format and divisor are frozen here for the whole frame.
    if (transfer) begin
      state_d      = StStart;
      hold_valid_d = 1'b0;
      shift_d      = hold_masked;
      bit_cnt_d    = 3'd0;
      par_en_d     = parity[PAR_EN];
      par_bit_d    = (^hold_masked) ^ ~parity[PAR_EVEN];
      eight_d      = eight_data_bits;
      two_stop_d   = extra_stop_bit;
      div_d        = clk_div_baud_in;
    end
  end

  always_comb begin
    frame_bit = 1'b1;
    unique case (state_q)
      StStart:  frame_bit = 1'b0;
      StData:   frame_bit = shift_q[0];
      StParity: frame_bit = par_bit_q;
      default:  frame_bit = 1'b1;
    endcase
  end

`ifdef UART_TX_BREAK_EN
  assign txd_d = break_en ? 1'b0 : frame_bit;
`else
  logic unused_break_en;
  assign unused_break_en = break_en;
  assign txd_d = frame_bit;
`endif

  always_ff @(posedge CLK50M or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      par_bit_q    <= 1'b0;
      par_en_q     <= 1'b0;
      eight_q      <= 1'b0;
      two_stop_q   <= 1'b0;
      div_q        <= '0;
      txd_q        <= 1'b1;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      par_bit_q    <= par_bit_d;
      par_en_q     <= par_en_d;
      eight_q      <= eight_d;
      two_stop_q   <= two_stop_d;
      div_q        <= div_d;
      txd_q        <= txd_d;
      busy_q       <= (state_q != StIdle);
      overrun_q    <= tx_load && hold_valid_q;
    end
  end

  // busy_q tracks the one-cycle lag of the registered pin so tx_empty waits for the last stop bit.
  assign TXD        = txd_q;
  assign tx_rdy     = !hold_valid_q;
  assign tx_empty   = !hold_valid_q && (state_q == StIdle) && !busy_q;
  assign tx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx: a frame-schedule model predicts TXD and status every cycle.
module tb_uart_tx;

  logic        CLK50M = 1'b0;
  logic        RST;
  logic [7:0]  tx_data_in;
  logic        tx_load;
  logic [1:0]  parity;
  logic        eight_data_bits;
  logic        extra_stop_bit;
  logic        break_en;
  logic [31:0] clk_div_baud_in;
  logic        TXD;
  logic        tx_rdy;
  logic        tx_empty;
  logic        tx_overrun;

  uart_tx dut (
    .CLK50M          (CLK50M),
    .RST             (RST),
    .tx_data_in      (tx_data_in),
    .tx_load         (tx_load),
    .parity          (parity),
    .eight_data_bits (eight_data_bits),
    .extra_stop_bit  (extra_stop_bit),
    .break_en        (break_en),
    .clk_div_baud_in (clk_div_baud_in),
    .TXD             (TXD),
    .tx_rdy          (tx_rdy),
    .tx_empty        (tx_empty),
    .tx_overrun      (tx_overrun)
  );

  always #10 CLK50M = ~CLK50M;

  // Pin timeline of one frame: [start, fin) in cycles, bit i lasts div cycles.
  typedef struct {
    int          load;
    int          start;
    int          fin;
    logic [11:0] bits;
    int          nbits;
    int          div;
  } frame_t;

  frame_t frames[$];
  int     cyc      = 0;
  int     last_end = 0;
  int     ovr_cyc  = -1;
  bit     mon_en   = 1'b0;
  int     n_tests  = 0;
  int     n_fail   = 0;
  logic   exp_bit;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic bit pending_at(input int c);
    foreach (frames[i]) if (frames[i].load <= c && c < frames[i].start - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit busy_at(input int c);
    foreach (frames[i]) if (frames[i].load <= c && c < frames[i].fin) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_txd(input int c);
    foreach (frames[i]) begin
      if (frames[i].start <= c && c < frames[i].fin)
        return frames[i].bits[(c - frames[i].start) / frames[i].div];
    end
    return 1'b1;
  endfunction

  // Cycle-by-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(posedge CLK50M);
      cyc++;
      #1;
      if (mon_en) begin
        exp_bit = exp_txd(cyc);
`ifdef UART_TX_BREAK_EN
        if (break_en) exp_bit = 1'b0;
`endif
        check_eq("txd", TXD, exp_bit);
        check_eq("tx_rdy", tx_rdy, !pending_at(cyc));
        check_eq("tx_empty", tx_empty, !busy_at(cyc));
        check_eq("tx_overrun", tx_overrun, cyc == ovr_cyc);
      end
    end
  end

  task automatic set_fmt(input logic [1:0] par, input logic eight, input logic two,
                         input logic [31:0] div);
    @(negedge CLK50M);
    parity          = par;
    eight_data_bits = eight;
    extra_stop_bit  = two;
    clk_div_baud_in = div;
  endtask

  task automatic do_load(input logic [7:0] d);
    frame_t     f;
    int         m;
    int         nd;
    logic [7:0] md;
    @(negedge CLK50M);
    tx_data_in = d;
    tx_load    = 1'b1;
    m = cyc + 1;
    if (pending_at(m - 1)) begin
      ovr_cyc = m;
    end else begin
      nd = eight_data_bits ? 8 : 7;
      md = eight_data_bits ? d : {1'b0, d[6:0]};
      f.bits  = '1;
      f.bits[0] = 1'b0;
      for (int i = 0; i < nd; i++) f.bits[1 + i] = md[i];
      f.nbits = 1 + nd;
      if (parity[0]) begin
        f.bits[f.nbits] = (^md) ^ !parity[1];
        f.nbits++;
      end
      f.nbits = f.nbits + 1 + (extra_stop_bit ? 1 : 0);
      f.div   = (clk_div_baud_in == 0) ? 1 : int'(clk_div_baud_in);
      f.load  = m;
      f.start = (m + 2 > last_end) ? m + 2 : last_end;
      f.fin   = f.start + f.nbits * f.div;
      last_end = f.fin;
      frames.push_back(f);
    end
    @(negedge CLK50M);
    tx_load = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc < last_end + 1) @(negedge CLK50M);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge CLK50M);
  endtask

  initial begin
    int s;
    int nloads;
    RST             = 1'b1;
    tx_data_in      = '0;
    tx_load         = 1'b0;
    parity          = '0;
    eight_data_bits = 1'b1;
    extra_stop_bit  = 1'b0;
    break_en        = 1'b0;
    clk_div_baud_in = 32'd1;
    repeat (3) @(negedge CLK50M);
    check_eq("rst_txd", TXD, 1'b1);
    check_eq("rst_rdy", tx_rdy, 1'b1);
    check_eq("rst_empty", tx_empty, 1'b1);
    check_eq("rst_overrun", tx_overrun, 1'b0);
    RST    = 1'b0;
    mon_en = 1'b1;

    set_fmt(2'b00, 1'b1, 1'b0, 32'd4);  // 8N1 0x55
    do_load(8'h55);
    wait_idle();
    set_fmt(2'b11, 1'b0, 1'b0, 32'd2);  // 7E1 0x41
    do_load(8'h41);
    wait_idle();
    set_fmt(2'b01, 1'b0, 1'b0, 32'd2);  // 7O1 0x41
    do_load(8'h41);
    wait_idle();
    set_fmt(2'b00, 1'b1, 1'b1, 32'd3);  // 8N2 0xFF
    do_load(8'hFF);
    wait_idle();

    // Back-to-back frames, then a load into a full holding register.
    set_fmt(2'b00, 1'b1, 1'b0, 32'd2);
    do_load(8'hA5);
    s = frames[frames.size() - 1].start;
    wait_until(s - 1);
    do_load(8'h3C);
    do_load(8'h99);
    wait_idle();

    // Break pulse in the middle of a frame.
    set_fmt(2'b01, 1'b1, 1'b0, 32'd3);
    do_load(8'hC3);
    s = frames[frames.size() - 1].start;
    wait_until(s + 5);
    @(negedge CLK50M);
    break_en = 1'b1;
    repeat (4) @(negedge CLK50M);
    break_en = 1'b0;
    wait_idle();

    // Reset during data bit 3, then a fresh frame.
    set_fmt(2'b00, 1'b1, 1'b0, 32'd4);
    do_load(8'h96);
    s = frames[frames.size() - 1].start;
    wait_until(s + 17);
    RST    = 1'b1;
    mon_en = 1'b0;
    #1;
    check_eq("midrst_txd", TXD, 1'b1);
    check_eq("midrst_rdy", tx_rdy, 1'b1);
    check_eq("midrst_empty", tx_empty, 1'b1);
    frames.delete();
    last_end = 0;
    ovr_cyc  = -1;
    @(negedge CLK50M);
    RST    = 1'b0;
    mon_en = 1'b1;
    do_load(8'h96);
    wait_idle();

    for (int t = 0; t < 30; t++) begin
      set_fmt(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 6)));
      nloads = $urandom_range(1, 3);
      for (int k = 0; k < nloads; k++) begin
        repeat ($urandom_range(0, 12)) @(negedge CLK50M);
        do_load(8'($urandom));
      end
      wait_idle();
    end

    repeat (3) @(negedge CLK50M);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
